accum_counter_bank: RTL

ACCUM_COUNTER_BANK -- requirements
Module: accum_counter_bank

---
 rtl/accum_counter_bank.sv | 86 ++++++++
 1 files changed

// File: rtl/accum_counter_bank.sv
// accum_counter_bank: registered adder, enable/clear counter bank with sticky overflow, snapshot streamer; define ACCUM_SATURATE_EN for saturating counters
module accum_counter_bank #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
) (
   input  logic                         sys_clk,
   input  logic                         sys_reset,
   input  logic [WIDTH-1:0]             sys_a,
   input  logic [WIDTH-1:0]             sys_b,
   output logic [WIDTH:0]               sys_sum,
   input  logic [CHANNELS-1:0]          sys_enable,
   input  logic [CHANNELS-1:0]          sys_clear,
   output logic [CHANNELS*WIDTH-1:0]    sys_count,
   output logic [CHANNELS-1:0]          sys_overflow,
   input  logic                         sys_snap_req,
   output logic                         sys_rd_valid,
   input  logic                         sys_rd_ready,
   output logic [WIDTH-1:0]             sys_rd_data,
   output logic [$clog2(CHANNELS)-1:0]  sys_rd_chan,
   output logic                         sys_snap_done
);
   localparam int IW = $clog2(CHANNELS);
   typedef enum logic {IDLE, STREAM} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] cnt [CHANNELS];
   logic [WIDTH-1:0] shadow [CHANNELS];
   logic [IW-1:0] idx;
   logic hs, last;
   assign hs = sys_rd_valid & sys_rd_ready;
   assign last = idx == IW'(CHANNELS - 1);
   for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
      assign sys_count[g*WIDTH +: WIDTH] = cnt[g];
   end
   // registered zero-extended sum, refreshed every cycle
   always_ff @(posedge sys_clk)
      sys_sum <= sys_reset ? '0 : {1'b0, sys_a} + {1'b0, sys_b};
   // counters: clear beats enable; overflow sticks until clear or reset
   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
         sys_overflow <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (sys_clear[i]) begin
               cnt[i] <= '0;
               sys_overflow[i] <= 1'b0;
            end else if (sys_enable[i]) begin
               if (&cnt[i]) sys_overflow[i] <= 1'b1;
`ifdef ACCUM_SATURATE_EN
               cnt[i] <= (&cnt[i]) ? cnt[i] : cnt[i] + 1'b1;
`else
               cnt[i] <= cnt[i] + 1'b1;
`endif
            end
         end
      end
   end
   // controller state register
   always_ff @(posedge sys_clk)
      state <= sys_reset ? IDLE : state_n;
   // next state: capture on request in IDLE, leave STREAM after last accepted word
   always_comb
      state_n = (state == IDLE) ? (sys_snap_req ? STREAM : IDLE) : ((hs && last) ? IDLE : STREAM);
   // snapshot capture, read index and completion pulse
   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         for (int i = 0; i < CHANNELS; i++) shadow[i] <= '0;
         idx <= '0;
         sys_snap_done <= 1'b0;
      end else begin
         sys_snap_done <= hs & last;
         if (state == IDLE && sys_snap_req) begin
            shadow <= cnt;
            idx <= '0;
         end else if (hs) begin
            idx <= last ? '0 : idx + 1'b1;
         end
      end
   end
   // read port shows the indexed shadow word while streaming, zeros otherwise
   always_comb begin
      sys_rd_valid = state == STREAM;
      sys_rd_data = sys_rd_valid ? shadow[idx] : '0;
      sys_rd_chan = sys_rd_valid ? idx : '0;
   end
endmodule
